// File: rtl/register_file_if.sv
// Decoder/ROB-facing signal bundle of the architectural register file.
// master = decoder + ROB side, slave = register file.
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

interface register_file_if #(
    parameter int unsigned ROB_SIZE_BIT = `ROB_WIDTH_BIT
);
    logic                    clear;
    logic [4:0]              set_reg_id;
    logic [31:0]             set_val;
    logic [ROB_SIZE_BIT-1:0] set_reg_on_rob_id;
    logic [4:0]              set_dep_reg_id;
    logic [ROB_SIZE_BIT-1:0] set_dep_rob_id;
    logic [4:0]              get_id1;
    logic [4:0]              get_id2;
    logic [ROB_SIZE_BIT-1:0] get_rob_id1;
    logic [ROB_SIZE_BIT-1:0] get_rob_id2;
    logic                    rob_value1_ready;
    logic                    rob_value2_ready;
    logic [31:0]             rob_value1;
    logic [31:0]             rob_value2;
    logic [31:0]             val1;
    logic [31:0]             val2;
    logic                    dep1_valid;
    logic                    dep2_valid;
    logic [ROB_SIZE_BIT-1:0] dep1_rob_id;
    logic [ROB_SIZE_BIT-1:0] dep2_rob_id;

    modport master (
        output clear, set_reg_id, set_val, set_reg_on_rob_id,
        output set_dep_reg_id, set_dep_rob_id, get_id1, get_id2,
        output rob_value1_ready, rob_value2_ready, rob_value1, rob_value2,
        input  get_rob_id1, get_rob_id2, val1, val2,
        input  dep1_valid, dep2_valid, dep1_rob_id, dep2_rob_id
    );

    modport slave (
        input  clear, set_reg_id, set_val, set_reg_on_rob_id,
        input  set_dep_reg_id, set_dep_rob_id, get_id1, get_id2,
        input  rob_value1_ready, rob_value2_ready, rob_value1, rob_value2,
        output get_rob_id1, get_rob_id2, val1, val2,
        output dep1_valid, dep2_valid, dep1_rob_id, dep2_rob_id
    );
endinterface

// File: rtl/register_file.sv
// Architectural register file with per-register busy flag and youngest-producer
// ROB id; two combinational operand reads with commit and ROB forwarding.
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

module register_file #(
    parameter int unsigned ROB_SIZE_BIT = `ROB_WIDTH_BIT
) (
    input logic           clk_in,
    input logic           rst_in,
    input logic           rdy_in,
    register_file_if.slave bus
);
    typedef logic [ROB_SIZE_BIT-1:0] rob_id_t;

    typedef struct packed {
        logic [31:0] val;
        logic        pend;
        rob_id_t     rob;
    } rd_res_t;

    logic [31:0] value_q [32];
    logic [31:0] value_d [32];
    logic [31:0] busy_q;
    logic [31:0] busy_d;
    rob_id_t     dep_q   [32];
    rob_id_t     dep_d   [32];

    logic        commit_en;
    logic        rename_en;
    logic        hit1;
    logic        hit2;
    rd_res_t     rd1;
    rd_res_t     rd2;

    assign commit_en = rdy_in && !bus.clear && (bus.set_reg_id != 5'd0);
    assign rename_en = rdy_in && !bus.clear && (bus.set_dep_reg_id != 5'd0);

    // Rename is applied after commit so it wins busy/dep on a same-register collision.
    always_comb begin
        value_d = value_q;
        busy_d  = busy_q;
        dep_d   = dep_q;
        if (rdy_in && bus.clear) begin
            busy_d = '0;
            for (int unsigned i = 0; i < 32; i++) begin
                dep_d[i] = '0;
            end
        end
        if (commit_en) begin
            value_d[bus.set_reg_id] = bus.set_val;
            if (busy_q[bus.set_reg_id] && (dep_q[bus.set_reg_id] == bus.set_reg_on_rob_id)) begin
                busy_d[bus.set_reg_id] = 1'b0;
            end
        end
        if (rename_en) begin
            busy_d[bus.set_dep_reg_id] = 1'b1;
            dep_d[bus.set_dep_reg_id]  = bus.set_dep_rob_id;
        end
        value_d[0] = '0;
        busy_d[0]  = 1'b0;
        dep_d[0]   = '0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                value_q[i] <= '0;
                dep_q[i]   <= '0;
            end
        end else begin
            value_q <= value_d;
            busy_q  <= busy_d;
            dep_q   <= dep_d;
        end
    end

    function automatic rd_res_t resolve(
        input logic [4:0]  id,
        input logic        busy,
        input logic [31:0] value,
        input rob_id_t     dep,
        input logic        commit_hit,
        input logic [31:0] commit_val,
        input logic        rob_ready,
        input logic [31:0] rob_val
    );
        rd_res_t r;
        r = '0;
        if (id == 5'd0) begin
            r.val = '0;
        end else if (!busy) begin
            r.val = value;
        end else if (commit_hit) begin
            r.val = commit_val;
        end else if (rob_ready) begin
            r.val = rob_val;
        end else begin
            r.pend = 1'b1;
            r.rob  = dep;
        end
        return r;
    endfunction

    assign hit1 = commit_en && (bus.set_reg_id == bus.get_id1)
                  && (bus.set_reg_on_rob_id == dep_q[bus.get_id1]);
    assign hit2 = commit_en && (bus.set_reg_id == bus.get_id2)
                  && (bus.set_reg_on_rob_id == dep_q[bus.get_id2]);

    always_comb begin
        rd1 = resolve(bus.get_id1, busy_q[bus.get_id1], value_q[bus.get_id1],
                      dep_q[bus.get_id1], hit1, bus.set_val,
                      bus.rob_value1_ready, bus.rob_value1);
        rd2 = resolve(bus.get_id2, busy_q[bus.get_id2], value_q[bus.get_id2],
                      dep_q[bus.get_id2], hit2, bus.set_val,
                      bus.rob_value2_ready, bus.rob_value2);
    end

    assign bus.get_rob_id1 = dep_q[bus.get_id1];
    assign bus.get_rob_id2 = dep_q[bus.get_id2];
    assign bus.val1        = rd1.val;
    assign bus.val2        = rd2.val;
    assign bus.dep1_valid  = rd1.pend;
    assign bus.dep2_valid  = rd2.pend;
    assign bus.dep1_rob_id = rd1.rob;
    assign bus.dep2_rob_id = rd2.rob;
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed vector table from the test plan, then
// randomized traffic against an array-based reference model, then mid-stream reset.
module tb_register_file;
    localparam int unsigned RW = 4;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   checks = 0;
    int   errors = 0;

    register_file_if #(.ROB_SIZE_BIT(RW)) bus ();

    register_file #(.ROB_SIZE_BIT(RW)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rdy, clr;
        logic [4:0]  sid;  logic [31:0] sval; logic [RW-1:0] srob;
        logic [4:0]  did;  logic [RW-1:0] drob;
        logic [4:0]  g1;   bit r1r; logic [31:0] r1v;
        logic [4:0]  g2;   bit r2r; logic [31:0] r2v;
        logic [31:0] v1;   bit p1; logic [RW-1:0] d1, gr1;
        logic [31:0] v2;   bit p2; logic [RW-1:0] d2, gr2;
    } vec_t;

    localparam int NV = 24;
    vec_t tv [NV];

    // reference state
    logic [31:0]   m_val  [32];
    bit            m_busy [32];
    logic [RW-1:0] m_dep  [32];

    function automatic vec_t mk(
        input logic [31:0] rdy_, clr, sid, sval, srob, did, drob,
        input logic [31:0] g1, r1r, r1v, g2, r2r, r2v,
        input logic [31:0] v1, p1, d1, gr1, v2, p2, d2, gr2
    );
        vec_t r;
        r.rdy = rdy_[0]; r.clr = clr[0];
        r.sid = sid[4:0]; r.sval = sval; r.srob = srob[RW-1:0];
        r.did = did[4:0]; r.drob = drob[RW-1:0];
        r.g1 = g1[4:0]; r.r1r = r1r[0]; r.r1v = r1v;
        r.g2 = g2[4:0]; r.r2r = r2r[0]; r.r2v = r2v;
        r.v1 = v1; r.p1 = p1[0]; r.d1 = d1[RW-1:0]; r.gr1 = gr1[RW-1:0];
        r.v2 = v2; r.p2 = p2[0]; r.d2 = d2[RW-1:0]; r.gr2 = gr2[RW-1:0];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        bus.clear = 1'b0;
        bus.set_reg_id = '0; bus.set_val = '0; bus.set_reg_on_rob_id = '0;
        bus.set_dep_reg_id = '0; bus.set_dep_rob_id = '0;
        bus.get_id1 = '0; bus.get_id2 = '0;
        bus.rob_value1_ready = 1'b0; bus.rob_value1 = '0;
        bus.rob_value2_ready = 1'b0; bus.rob_value2 = '0;
    endtask

    task automatic check_outputs(input string tag,
                                 input logic [31:0] v1, input bit p1, input logic [RW-1:0] d1, gr1,
                                 input logic [31:0] v2, input bit p2, input logic [RW-1:0] d2, gr2);
        chk({tag, " val1"},        bus.val1, v1);
        chk({tag, " dep1_valid"},  32'(bus.dep1_valid), 32'(p1));
        chk({tag, " dep1_rob_id"}, 32'(bus.dep1_rob_id), 32'(d1));
        chk({tag, " get_rob_id1"}, 32'(bus.get_rob_id1), 32'(gr1));
        chk({tag, " val2"},        bus.val2, v2);
        chk({tag, " dep2_valid"},  32'(bus.dep2_valid), 32'(p2));
        chk({tag, " dep2_rob_id"}, 32'(bus.dep2_rob_id), 32'(d2));
        chk({tag, " get_rob_id2"}, 32'(bus.get_rob_id2), 32'(gr2));
    endtask

    // Operand resolution straight from the rules: x0, idle register, same-cycle
    // matching commit, ROB forward, else pending on the recorded producer.
    task automatic model_read(input logic [4:0] id, input bit rr, input logic [31:0] rv,
                              output logic [31:0] v, output bit p,
                              output logic [RW-1:0] d, output logic [RW-1:0] gr);
        bit commit_now;
        commit_now = rdy && !bus.clear && bus.set_reg_id != 0;
        gr = m_dep[id];
        v = '0; p = 1'b0; d = '0;
        if (id == 0) v = '0;
        else if (!m_busy[id]) v = m_val[id];
        else if (commit_now && bus.set_reg_id == id && bus.set_reg_on_rob_id == m_dep[id]) v = bus.set_val;
        else if (rr) v = rv;
        else begin p = 1'b1; d = m_dep[id]; end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0; m_busy[i] = 1'b0; m_dep[i] = '0;
        end
    endtask

    task automatic model_step();
        if (rst) model_reset();
        else if (rdy) begin
            if (bus.clear) begin
                for (int i = 0; i < 32; i++) begin m_busy[i] = 1'b0; m_dep[i] = '0; end
            end else begin
                if (bus.set_reg_id != 0) begin
                    m_val[bus.set_reg_id] = bus.set_val;
                    if (m_busy[bus.set_reg_id] && m_dep[bus.set_reg_id] == bus.set_reg_on_rob_id)
                        m_busy[bus.set_reg_id] = 1'b0;
                end
                if (bus.set_dep_reg_id != 0) begin
                    m_busy[bus.set_dep_reg_id] = 1'b1;
                    m_dep[bus.set_dep_reg_id]  = bus.set_dep_rob_id;
                end
            end
        end
    endtask

    initial begin
        logic [31:0]   ev1, ev2;
        bit            ep1, ep2;
        logic [RW-1:0] ed1, ed2, eg1, eg2;

        //          rdy clr sid  sval     srob did drob g1 r1r r1v      g2 r2r r2v      v1       p1 d1 gr1 v2      p2 d2 gr2
        tv[0]  = mk(1, 0,  0,  0,       0,   0,  0,   5, 0, 0,       0, 0, 0,       0,       0, 0, 0,  0,      0, 0, 0);
        tv[1]  = mk(1, 0,  0,  0,       0,   3,  7,   3, 0, 0,       0, 0, 0,       0,       0, 0, 0,  0,      0, 0, 0);
        tv[2]  = mk(1, 0,  0,  0,       0,   0,  0,   3, 0, 0,       0, 0, 0,       0,       1, 7, 7,  0,      0, 0, 0);
        tv[3]  = mk(1, 0,  0,  0,       0,   0,  0,   3, 1, 'h1234,  0, 0, 0,       'h1234,  0, 0, 7,  0,      0, 0, 0);
        tv[4]  = mk(1, 0,  3,  'hAA,    7,   0,  0,   3, 0, 0,       0, 0, 0,       'hAA,    0, 0, 7,  0,      0, 0, 0);
        tv[5]  = mk(1, 0,  0,  0,       0,   0,  0,   3, 0, 0,       0, 0, 0,       'hAA,    0, 0, 7,  0,      0, 0, 0);
        tv[6]  = mk(1, 0,  0,  0,       0,   4,  2,   3, 0, 0,       4, 0, 0,       'hAA,    0, 0, 7,  0,      0, 0, 0);
        tv[7]  = mk(1, 0,  0,  0,       0,   4,  9,   3, 0, 0,       4, 0, 0,       'hAA,    0, 0, 7,  0,      1, 2, 2);
        tv[8]  = mk(1, 0,  4,  'h55,    2,   0,  0,   3, 0, 0,       4, 0, 0,       'hAA,    0, 0, 7,  0,      1, 9, 9);
        tv[9]  = mk(1, 0,  0,  0,       0,   0,  0,   3, 0, 0,       4, 1, 'hBEEF,  'hAA,    0, 0, 7,  'hBEEF, 0, 0, 9);
        tv[10] = mk(1, 0,  0,  0,       0,   6,  1,   0, 0, 0,       6, 0, 0,       0,       0, 0, 0,  0,      0, 0, 0);
        tv[11] = mk(1, 0,  6,  'h66,    1,   6,  5,   0, 0, 0,       6, 0, 0,       0,       0, 0, 0,  'h66,   0, 0, 1);
        tv[12] = mk(1, 0,  0,  0,       0,   0,  0,   0, 0, 0,       6, 0, 0,       0,       0, 0, 0,  0,      1, 5, 5);
        tv[13] = mk(1, 0,  1,  'h11,    0,   2,  3,   1, 0, 0,       2, 0, 0,       0,       0, 0, 0,  0,      0, 0, 0);
        tv[14] = mk(1, 0,  31, 'h31,    0,   1,  4,   1, 0, 0,       31,0, 0,       'h11,    0, 0, 0,  0,      0, 0, 0);
        tv[15] = mk(1, 0,  2,  'h22,    8,   31, 6,   2, 0, 0,       1, 0, 0,       0,       1, 3, 3,  0,      1, 4, 4);
        tv[16] = mk(1, 0,  0,  'hFF,    0,   0,  5,   0, 0, 0,       2, 0, 0,       0,       0, 0, 0,  0,      1, 3, 3);
        tv[17] = mk(1, 1,  5,  'h77,    0,   7,  8,   31,0, 0,       0, 0, 0,       0,       1, 6, 6,  0,      0, 0, 0);
        tv[18] = mk(1, 0,  0,  0,       0,   0,  0,   31,0, 0,       2, 0, 0,       'h31,    0, 0, 0,  'h22,   0, 0, 0);
        tv[19] = mk(1, 0,  0,  0,       0,   0,  0,   1, 0, 0,       5, 0, 0,       'h11,    0, 0, 0,  0,      0, 0, 0);
        tv[20] = mk(1, 0,  0,  0,       0,   0,  0,   6, 0, 0,       4, 0, 0,       'h66,    0, 0, 0,  'h55,   0, 0, 0);
        tv[21] = mk(0, 0,  7,  'h99,    0,   1,  2,   1, 0, 0,       7, 0, 0,       'h11,    0, 0, 0,  0,      0, 0, 0);
        tv[22] = mk(1, 0,  0,  0,       0,   0,  0,   1, 0, 0,       7, 0, 0,       'h11,    0, 0, 0,  0,      0, 0, 0);
        tv[23] = mk(1, 0,  0,  0,       0,   0,  0,   3, 0, 0,       0, 0, 0,       'hAA,    0, 0, 0,  0,      0, 0, 0);

        rst = 1'b1;
        rdy = 1'b1;
        set_idle();
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst = 1'b0;
            rdy = tv[i].rdy;
            bus.clear = tv[i].clr;
            bus.set_reg_id = tv[i].sid; bus.set_val = tv[i].sval; bus.set_reg_on_rob_id = tv[i].srob;
            bus.set_dep_reg_id = tv[i].did; bus.set_dep_rob_id = tv[i].drob;
            bus.get_id1 = tv[i].g1; bus.rob_value1_ready = tv[i].r1r; bus.rob_value1 = tv[i].r1v;
            bus.get_id2 = tv[i].g2; bus.rob_value2_ready = tv[i].r2r; bus.rob_value2 = tv[i].r2v;
            #1;
            check_outputs($sformatf("vec%0d", i), tv[i].v1, tv[i].p1, tv[i].d1, tv[i].gr1,
                          tv[i].v2, tv[i].p2, tv[i].d2, tv[i].gr2);
        end

        // randomized traffic against the reference model
        @(negedge clk);
        set_idle();
        rst = 1'b1; rdy = 1'b1;
        @(posedge clk);
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 149) == 0);
            rdy = ($urandom_range(0, 7) != 0);
            bus.clear = ($urandom_range(0, 24) == 0);
            bus.get_id1 = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            bus.get_id2 = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            bus.set_reg_id = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) bus.set_reg_id = bus.get_id1;
            bus.set_reg_on_rob_id = $urandom_range(0, 1) ? m_dep[bus.set_reg_id] : RW'($urandom);
            bus.set_val = $urandom;
            bus.set_dep_reg_id = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
            bus.set_dep_rob_id = RW'($urandom);
            bus.rob_value1_ready = ($urandom_range(0, 2) == 0);
            bus.rob_value2_ready = ($urandom_range(0, 2) == 0);
            bus.rob_value1 = $urandom;
            bus.rob_value2 = $urandom;
            #1;
            model_read(bus.get_id1, bus.rob_value1_ready, bus.rob_value1, ev1, ep1, ed1, eg1);
            model_read(bus.get_id2, bus.rob_value2_ready, bus.rob_value2, ev2, ep2, ed2, eg2);
            check_outputs($sformatf("rand%0d", n), ev1, ep1, ed1, eg1, ev2, ep2, ed2, eg2);
            model_step();
        end

        // mid-stream reset: load some state, reset alongside a rename/commit, then scan all registers
        @(negedge clk);
        rst = 1'b0; rdy = 1'b1; set_idle();
        bus.set_dep_reg_id = 5'd9; bus.set_dep_rob_id = RW'(3);
        bus.set_reg_id = 5'd10; bus.set_val = 32'hCAFE_0010;
        @(negedge clk);
        rst = 1'b1;
        bus.set_dep_reg_id = 5'd11; bus.set_reg_id = 5'd12; bus.set_val = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b0; set_idle();
        for (int i = 0; i < 16; i++) begin
            bus.get_id1 = 5'(i);
            bus.get_id2 = 5'(31 - i);
            #1;
            check_outputs($sformatf("post_reset%0d", i), '0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
